fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 21 ++
 rtl/rr_pick.sv | 30 +++
 rtl/fifo_wr_arbiter.sv | 133 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared constants and types for the FIFO write arbiter.
package fifo_arb_pkg;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefNumReq    = 4;
  localparam int unsigned DefBurstMax  = 4;

  // Beat counter is 5 bits so it can hold BURST_MAX up to 16.
  localparam int unsigned BeatW = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Saturating increment for the 16-bit write counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    ptr_i,
  output logic               found_o,
  output logic [IdxW-1:0]    idx_o
);

  // Scan from the pointer upward; the first hit wins.
  always_comb begin
    int unsigned cand;
    cand    = 0;
    found_o = 1'b0;
    idx_o   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(ptr_i) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter granting bursts of requester words into a FIFO write port.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned NUM_REQ    = DefNumReq,
  parameter int unsigned BURST_MAX  = DefBurstMax,
  localparam int unsigned IdxW      = $clog2(NUM_REQ)
) (
  input  logic                          clk1,
  input  logic                          wrst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          fifo_full,
  input  logic                          fifo_almost_full,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         din,
  output logic [IdxW-1:0]               owner,
  output logic                          busy,
  output logic [15:0]                   words_written
);

  arb_state_e            state_q;
  logic [IdxW-1:0]       owner_q;
  logic [IdxW-1:0]       rr_ptr_q;
  logic [BeatW-1:0]      beat_q;
  logic                  wr_en_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic [15:0]           words_q;

  logic                  pick_found;
  logic [IdxW-1:0]       pick_idx;
  logic [IdxW-1:0]       next_ptr;
  logic                  own_req;
  logic                  own_last;
  logic [DATA_WIDTH-1:0] own_data;
  logic                  fifo_ready;
  logic                  accept;
  logic                  burst_end;
  logic [BeatW-1:0]      beat_inc;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_pick (
    .req_i  (req),
    .ptr_i  (rr_ptr_q),
    .found_o(pick_found),
    .idx_o  (pick_idx)
  );

  // Route the owning requester's valid, last flag and data word.
  always_comb begin
    own_req  = 1'b0;
    own_last = 1'b0;
    own_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IdxW'(i)) begin
        own_req  = req[i];
        own_last = req_last[i];
        own_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Almost-full already guarantees a free slot, but we stall on it to leave headroom.
  assign fifo_ready = ~fifo_full & ~fifo_almost_full;
  assign accept     = (state_q == BURST) & own_req & fifo_ready & ~wrst;
  assign beat_inc   = beat_q + 5'd1;

  // A dropped request ends the burst even while the FIFO is stalling us.
  assign burst_end  = ~own_req | (accept & (own_last | (beat_inc == BeatW'(BURST_MAX))));

  assign next_ptr   = (owner_q == IdxW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  // One-hot accept strobe toward the current owner only.
  always_comb begin
    gnt          = '0;
    gnt[owner_q] = accept;
  end

  // Arbitration FSM with registered write port.
  always_ff @(posedge clk1) begin
    if (wrst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      beat_q   <= '0;
      wr_en_q  <= 1'b0;
      din_q    <= '0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            owner_q <= pick_idx;
            beat_q  <= '0;
            state_q <= BURST;
          end
        end
        BURST: begin
          if (accept) begin
            wr_en_q <= 1'b1;
            din_q   <= own_data;
            beat_q  <= beat_inc;
          end
          if (burst_end) begin
            state_q  <= IDLE;
            rr_ptr_q <= next_ptr;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Count completed FIFO writes, saturating at all-ones.
  always_ff @(posedge clk1) begin
    if (wrst) begin
      words_q <= '0;
    end else if (wr_en_q) begin
      words_q <= sat_inc16(words_q);
    end
  end

  assign wr_en         = wr_en_q;
  assign din           = din_q;
  assign owner         = owner_q;
  assign busy          = (state_q == BURST);
  assign words_written = words_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised and directed bench for fifo_wr_arbiter with an in-bench behavioural model.
module tb_fifo_wr_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int BM = 4;

  logic              clk1 = 1'b0;
  logic              wrst = 1'b1;
  logic [NR-1:0]     req = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [NR-1:0]     req_last = '0;
  logic [NR-1:0]     gnt;
  logic              fifo_full = 1'b0;
  logic              fifo_almost_full = 1'b0;
  logic              wr_en;
  logic [DW-1:0]     din;
  logic [1:0]        owner;
  logic              busy;
  logic [15:0]       words_written;

  fifo_wr_arbiter #(
    .DATA_WIDTH(DW),
    .NUM_REQ   (NR),
    .BURST_MAX (BM)
  ) dut (
    .clk1            (clk1),
    .wrst            (wrst),
    .req             (req),
    .req_data        (req_data),
    .req_last        (req_last),
    .gnt             (gnt),
    .fifo_full       (fifo_full),
    .fifo_almost_full(fifo_almost_full),
    .wr_en           (wr_en),
    .din             (din),
    .owner           (owner),
    .busy            (busy),
    .words_written   (words_written)
  );

  always #5 clk1 = ~clk1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state.
  bit            m_en = 0;
  bit            m_busy;
  int            m_owner, m_ptr, m_beat, m_ww;
  bit            m_wr;
  logic [DW-1:0] m_din;

  // Requester stimulus state: words still to offer per requester.
  int            rem[NR];
  bit            use_last[NR];
  logic [DW-1:0] wdata[NR];
  bit            rand_mode = 0;
  logic [NR-1:0] obs_gnt = '0;

  // Observations of the DUT for the directed literal checks.
  int cyc = 0;
  int gnt_cnt, gnt_first, gnt_last, wr_cnt, wr_first, cur_len;
  int own_q[$];
  int len_q[$];
  int rise_q[$];
  bit prev_busy = 0;

  // Compare against the model, log observations, then advance the model one cycle.
  always @(negedge clk1) begin
    logic [NR-1:0] eg;
    bit acc;
    cyc++;
    eg = '0;
    if (m_en && m_busy && !wrst && req[m_owner] && !fifo_almost_full && !fifo_full)
      eg[m_owner] = 1'b1;
    if (m_en || wrst) check("gnt", gnt, eg);
    if (m_en) begin
      check("busy", busy, m_busy);
      check("owner", owner, m_owner);
      check("wr_en", wr_en, m_wr);
      if (m_wr) check("din", din, m_din);
      check("words_written", words_written, m_ww);
    end
    obs_gnt = gnt;

    if (|gnt) begin
      gnt_cnt++;
      if (gnt_first < 0) gnt_first = cyc;
      gnt_last = cyc;
    end
    if (wr_en) begin
      wr_cnt++;
      if (wr_first < 0) wr_first = cyc;
    end
    if (busy && !prev_busy) begin
      own_q.push_back(int'(owner));
      rise_q.push_back(cyc);
      cur_len = 0;
    end
    if (busy && (|gnt)) cur_len++;
    if (!busy && prev_busy) len_q.push_back(cur_len);
    prev_busy = busy;

    if (wrst) begin
      m_en = 1; m_busy = 0; m_owner = 0; m_ptr = 0; m_beat = 0;
      m_wr = 0; m_din = '0; m_ww = 0;
    end else if (m_en) begin
      acc = (eg != 0);
      if (m_wr) m_ww = (m_ww == 65535) ? 65535 : m_ww + 1;
      m_wr = acc;
      if (!m_busy) begin
        for (int k = 0; k < NR; k++) begin
          if (req[(m_ptr + k) % NR]) begin
            m_owner = (m_ptr + k) % NR;
            m_beat  = 0;
            m_busy  = 1;
            break;
          end
        end
      end else begin
        if (acc) begin
          m_din = req_data[m_owner*DW +: DW];
          m_beat++;
        end
        if (!req[m_owner] || (acc && (req_last[m_owner] || m_beat == BM))) begin
          m_busy = 0;
          m_ptr  = (m_owner + 1) % NR;
        end
      end
    end
  end

  task automatic apply();
    for (int i = 0; i < NR; i++) begin
      req[i]                = (rem[i] > 0);
      req_last[i]           = use_last[i] && (rem[i] == 1);
      req_data[i*DW +: DW]  = wdata[i];
    end
  endtask

  task automatic consume();
    for (int i = 0; i < NR; i++) begin
      if (obs_gnt[i] && rem[i] > 0) begin
        rem[i]--;
        wdata[i] = DW'($urandom);
      end
      if (rand_mode) begin
        if (rem[i] == 0 && $urandom_range(0, 3) == 0) begin
          rem[i]      = $urandom_range(1, 7);
          use_last[i] = 1'($urandom_range(0, 1));
        end else if (rem[i] > 0 && $urandom_range(0, 19) == 0) begin
          rem[i] = 0;
        end
      end
    end
    if (rand_mode) begin
      fifo_almost_full = ($urandom_range(0, 4) == 0);
      fifo_full        = ($urandom_range(0, 9) == 0);
    end
  endtask

  task automatic step();
    @(posedge clk1);
    #1;
    consume();
    apply();
  endtask

  task automatic clr();
    gnt_cnt = 0; gnt_first = -1; gnt_last = -1;
    wr_cnt = 0; wr_first = -1; cur_len = 0;
    own_q.delete(); len_q.delete(); rise_q.delete();
  endtask

  task automatic reset_dut();
    rand_mode = 0;
    fifo_almost_full = 0;
    fifo_full = 0;
    for (int i = 0; i < NR; i++) begin
      rem[i] = 0;
      use_last[i] = 0;
      wdata[i] = DW'($urandom);
    end
    wrst = 1;
    step();
    step();
    wrst = 0;
    clr();
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  initial begin
    int t0;
    int g0;

    // Reset state.
    reset_dut();
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_words", words_written, 0);
    check("rst_gnt", gnt, 0);

    // Single requester, three-word burst ending on req_last.
    reset_dut();
    rem[0] = 3; use_last[0] = 1; wdata[0] = 8'hA1;
    apply();
    t0 = cyc;
    repeat (8) step();
    check("t1_gnt_cnt", gnt_cnt, 3);
    check("t1_gnt_start", gnt_first - t0, 2);
    check("t1_gnt_span", gnt_last - gnt_first, 2);
    check("t1_wr_cnt", wr_cnt, 3);
    check("t1_wr_lat", wr_first - gnt_first, 1);
    check("t1_words", words_written, 3);

    // All requesting, no last: max-length bursts rotate 0,1,2,3,0.
    reset_dut();
    for (int i = 0; i < NR; i++) rem[i] = 1000;
    apply();
    repeat (26) step();
    for (int i = 0; i < NR; i++) rem[i] = 0;
    apply();
    repeat (4) step();
    for (int i = 0; i < 5; i++) begin
      check("t2_owner", qget(own_q, i), i % NR);
      check("t2_len", qget(len_q, i), BM);
    end
    check("t2_spacing", qget(rise_q, 4) - qget(rise_q, 0), 20);

    // Owner 2 stalled by almost-full for five cycles mid-burst.
    reset_dut();
    rem[2] = 1000;
    apply();
    repeat (3) step();
    fifo_almost_full = 1;
    g0 = gnt_cnt;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_stall_owner", owner, 2);
      check("t3_stall_busy", busy, 1);
    end
    check("t3_stall_gnt", gnt_cnt - g0, 0);
    fifo_almost_full = 0;
    step();
    check("t3_stall_wr", wr_cnt, 2);
    repeat (3) step();
    rem[2] = 0;
    apply();
    repeat (3) step();
    check("t3_len", qget(len_q, 0), 4);

    // Requester 1 drops after two words; next grant goes to 3, not 0.
    reset_dut();
    rem[1] = 2;
    apply();
    repeat (2) step();
    rem[0] = 1000; rem[3] = 1000;
    apply();
    repeat (8) step();
    check("t4_owner0", qget(own_q, 0), 1);
    check("t4_len0", qget(len_q, 0), 2);
    check("t4_owner1", qget(own_q, 1), 3);
    for (int i = 0; i < NR; i++) rem[i] = 0;
    apply();
    repeat (8) step();

    // Reset pulse mid-burst drops the in-flight write.
    reset_dut();
    rem[0] = 1000;
    apply();
    repeat (3) step();
    check("t5_pre_wr", wr_en, 1);
    wrst = 1;
    step();
    wrst = 0;
    check("t5_wr_en", wr_en, 0);
    check("t5_busy", busy, 0);
    check("t5_owner", owner, 0);
    check("t5_words", words_written, 0);

    // Saturation of the write counter.
    reset_dut();
    dut.words_q = 16'hFFFE;
    m_ww = 65534;
    rem[0] = 3; use_last[0] = 1;
    apply();
    repeat (10) step();
    check("t6_sat", words_written, 16'hFFFF);

    // Randomised traffic with occasional reset pulses.
    reset_dut();
    rand_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      wrst = (i % 700 == 350);
      step();
    end
    wrst = 0;
    rand_mode = 0;
    fifo_almost_full = 0;
    fifo_full = 0;
    for (int i = 0; i < NR; i++) rem[i] = 0;
    apply();
    repeat (6) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
